// File: rtl/mix_seq_pkg.sv
// Shared types and constants for the mix round sequencer: lane vector layout,
// phase/state encodings and the per-lane multiply/add tables used by MUL.
package mix_seq_pkg;
  localparam int LANES  = 8;
  localparam int NPHASE = 5;
  localparam int RND_W  = 8;

  typedef enum logic [2:0] {PH_ADDC, PH_CHAIN, PH_XSH, PH_FBK, PH_MUL} phase_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_e;

  // Packed so lane i lands on bits [32i+31:32i] of a flat 256-bit bus.
  typedef logic [LANES-1:0][31:0] lane_vec_t;

  localparam logic [31:0] MUL_K [LANES] = '{32'd2, 32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19};
  localparam logic [31:0] ADD_K [LANES] = '{32'd3, 32'd5, 32'd7, 32'd11, 32'd13, 32'd17, 32'd19, 32'd23};
endpackage

// File: rtl/mix_phase_unit.sv
// One mixing phase applied to all lanes. Lanes are updated in index order so
// lane i observes the already-updated lanes below it.
module mix_phase_unit
  import mix_seq_pkg::*;
(
  input  lane_vec_t lanes,
  input  phase_e    phase,
  input  logic      en,
  output lane_vec_t lanes_out
);
  always_comb begin
    lanes_out = lanes;
    if (en) begin
      case (phase)
        PH_ADDC:
          for (int i = 0; i < LANES; i++) lanes_out[i] = lanes_out[i] + 32'(i);
        PH_CHAIN: begin
          lanes_out[0] = lanes_out[0] + lanes_out[LANES-1];
          for (int i = 1; i < LANES; i++) lanes_out[i] = lanes_out[i] + lanes_out[i-1];
        end
        PH_XSH:
          for (int i = 0; i < LANES; i++)
            lanes_out[i] = lanes_out[i] ^ (lanes_out[(i+3)%LANES] << 16);
        PH_FBK:
          for (int i = 0; i < LANES; i++)
            lanes_out[i] = lanes_out[i] + lanes_out[(i+LANES-1)%LANES]
                           - lanes_out[(i+LANES-2)%LANES];
        PH_MUL:
          for (int i = 0; i < LANES; i++) lanes_out[i] = lanes_out[i] * MUL_K[i] + ADD_K[i];
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mix_round_sequencer.sv
// Fixed-latency multi-cycle mixing engine: one phase per clock, result held
// under valid/ready until consumed.
module mix_round_sequencer
  import mix_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [255:0]     in_seed,
  input  logic [RND_W-1:0] in_rounds,
  input  logic [4:0]       in_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [255:0]     out_data,
  output logic             busy
);
  localparam logic [RND_W-1:0] RND_ONE = 1;

  state_e           state, state_nx;
  lane_vec_t        lanes, lanes_nx;
  logic [RND_W-1:0] rounds_q, round_cnt;
  logic [4:0]       mask_q;
  logic [2:0]       phase_cnt;
  logic             accept, last_step, phase_en;

  assign in_ready  = (state == S_IDLE) | ((state == S_HOLD) & out_valid & out_ready);
  assign accept    = in_valid & in_ready;
  assign busy      = (state == S_RUN);
  assign last_step = (phase_cnt == 3'(NPHASE-1)) && (round_cnt == rounds_q - RND_ONE);
  assign phase_en  = mask_q[phase_cnt];

  mix_phase_unit u_phase (
    .lanes    (lanes),
    .phase    (phase_e'(phase_cnt)),
    .en       (phase_en),
    .lanes_out(lanes_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (last_step) state_nx = S_HOLD;
      S_HOLD:  if (out_valid & out_ready) state_nx = S_IDLE;
      default: ;
    endcase
    // A job can be taken from IDLE or in the same cycle the held result drains.
    if (accept) state_nx = (in_rounds == '0) ? S_HOLD : S_RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lanes     <= '0;
      rounds_q  <= '0;
      mask_q    <= '0;
      phase_cnt <= '0;
      round_cnt <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        lanes     <= in_seed;
        rounds_q  <= in_rounds;
        mask_q    <= in_mask;
        phase_cnt <= '0;
        round_cnt <= '0;
      end else if (state == S_RUN) begin
        lanes <= lanes_nx;
        if (phase_cnt == 3'(NPHASE-1)) begin
          phase_cnt <= '0;
          round_cnt <= round_cnt + RND_ONE;
        end else begin
          phase_cnt <= phase_cnt + 3'd1;
        end
      end
      // First HOLD cycle publishes the lanes; out_data is frozen until drained.
      if (state == S_HOLD) begin
        if (!out_valid) begin
          out_valid <= 1'b1;
          out_data  <= lanes;
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_mix_round_sequencer.sv
// Scoreboard bench for mix_round_sequencer: directed jobs push expected
// result and latency; a monitor compares each result as out_valid rises.
module tb_mix_round_sequencer;
  import mix_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, out_valid, out_ready, busy;
  logic [255:0]     in_seed, out_data;
  logic [RND_W-1:0] in_rounds;
  logic [4:0]       in_mask;

  mix_round_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_seed(in_seed), .in_rounds(in_rounds), .in_mask(in_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {logic [255:0] data; int lat;} exp_t;
  exp_t exp_q[$];
  int   acc_q[$];
  int   vectors = 0, fails = 0, cyc = 0;
  logic prev_v = 1'b0;

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic logic [255:0] model(logic [255:0] seed, int rounds, logic [4:0] mask);
    int unsigned o[8];
    int unsigned mk[8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int unsigned ak[8] = '{3, 5, 7, 11, 13, 17, 19, 23};
    logic [255:0] r;
    for (int i = 0; i < 8; i++) o[i] = seed[32*i +: 32];
    for (int rd = 0; rd < rounds; rd++)
      for (int p = 0; p < 5; p++)
        if (mask[p]) begin
          case (p)
            0: for (int i = 0; i < 8; i++) o[i] = o[i] + i;
            1: begin
              o[0] = o[0] + o[7];
              for (int i = 1; i < 8; i++) o[i] = o[i] + o[i-1];
            end
            2: for (int i = 0; i < 8; i++) o[i] = o[i] ^ (o[(i+3)%8] << 16);
            3: for (int i = 0; i < 8; i++) o[i] = o[i] + o[(i+7)%8] - o[(i+6)%8];
            default: for (int i = 0; i < 8; i++) o[i] = o[i] * mk[i] + ak[i];
          endcase
        end
    for (int i = 0; i < 8; i++) r[32*i +: 32] = o[i];
    return r;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_n && in_valid && in_ready) acc_q.push_back(cyc);
  end

  always @(negedge clk) begin
    if (!rst_n) prev_v = 1'b0;
    else begin
      if (out_valid && !prev_v) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          vectors++; fails++;
          $display("FAIL unexpected_result: got %h want none", out_data);
        end else begin
          exp_t e;
          int   a;
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_data", out_data, e.data);
          check("latency", 256'(cyc - a), 256'(e.lat));
        end
      end
      prev_v = out_valid;
    end
  end

  task automatic send(logic [255:0] seed, int rounds, logic [4:0] mask, logic [255:0] want);
    logic got;
    exp_q.push_back('{data: want, lat: 5*rounds+1});
    @(negedge clk);
    in_valid = 1'b1; in_seed = seed; in_rounds = RND_W'(rounds); in_mask = mask;
    for (int t = 0; t <= 4000; t++) begin
      #1 got = in_ready;
      @(posedge clk);
      if (got) break;
      if (t == 4000) begin
        vectors++; fails++;
        $display("FAIL accept_timeout: got no accept want accept");
      end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t <= 5000; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
      if (t == 5000) begin
        vectors++; fails++;
        $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] s, w;
    int t2[8] = '{2, 3, 4, 5, 6, 7, 8, 9};
    int t3[8] = '{5, 8, 12, 18, 24, 30, 36, 42};
    rst_n = 1'b0; in_valid = 1'b0; in_seed = '0; in_rounds = '0; in_mask = '0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_out_data", out_data, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("rel_in_ready", 256'(in_ready), 256'(1));

    // 1: ADDC only, 3 rounds
    for (int i = 0; i < 8; i++) w[32*i +: 32] = 32'(3*i);
    send('0, 3, 5'b00001, w);
    drain();
    // 2: CHAIN only
    for (int i = 0; i < 8; i++) begin s[32*i +: 32] = 32'd1; w[32*i +: 32] = 32'(t2[i]); end
    send(s, 1, 5'b00010, w);
    drain();
    // 3: MUL only
    for (int i = 0; i < 8; i++) w[32*i +: 32] = 32'(t3[i]);
    send(s, 1, 5'b10000, w);
    drain();
    // 4: zero rounds passes seed through
    for (int i = 0; i < 8; i++) s[32*i +: 32] = 32'h1111_1111 * 32'(i);
    send(s, 0, 5'b11111, s);
    drain();

    // 5: backpressure then simultaneous drain + accept
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) s[32*i +: 32] = 32'hA5A5_0000 + 32'(i);
    w = model(s, 2, 5'b11111);
    send(s, 2, 5'b11111, w);
    for (int t = 0; t < 200 && !out_valid; t++) @(negedge clk);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_out_data", out_data, w);
      check("bp_out_valid", 256'(out_valid), 256'(1));
      check("bp_in_ready", 256'(in_ready), 256'(0));
    end
    s = ~s;
    exp_q.push_back('{data: model(s, 3, 5'b10101), lat: 16});
    in_valid = 1'b1; in_seed = s; in_rounds = 8'd3; in_mask = 5'b10101; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_out_valid", 256'(out_valid), 256'(0));
    check("bp_next_busy", 256'(busy), 256'(1));
    drain();

    // 6: async reset during round 2 aborts the job
    send(s, 4, 5'b11111, model(s, 4, 5'b11111));
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 256'(out_valid), 256'(0));
    check("abort_busy", 256'(busy), 256'(0));
    exp_q.delete(); acc_q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("abort_in_ready", 256'(in_ready), 256'(1));
    send(s, 4, 5'b11111, model(s, 4, 5'b11111));
    drain();

    // 7: random jobs against the reference model, including max rounds
    for (int n = 0; n < 200; n++) begin
      int r;
      logic [4:0] m;
      for (int i = 0; i < 8; i++) s[32*i +: 32] = $urandom;
      r = (n == 0) ? 255 : int'($urandom_range(0, 12));
      m = 5'($urandom);
      send(s, r, m, model(s, r, m));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
